// File: rtl/status_frame_tx.sv
// Status frame transmitter: EB 90 seq TAG payload chk 09 D7 into the UART TX FIFO.
// Heartbeat frames are built in when STATUS_FRAME_HEARTBEAT_EN is defined.
module status_frame_tx #(
    parameter int         FIFO_DEPTH = 16,
    parameter int         COUNTER_W  = 5,
    parameter logic [7:0] TAG        = 8'hBA,
    parameter int         GAP_CYCLES = 640,
    parameter int         PERIOD     = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send_req,
    input  logic [7:0]           status_in,
    input  logic [COUNTER_W-1:0] tf_counter,
    output logic                 tf_push,
    output logic [7:0]           tdr,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           seq_out
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t        state;
    state_t        state_next;
    logic          pending;
    logic          hb_tick;
    logic [7:0]    payload;
    logic [7:0]    chk;
    logic [2:0]    idx;
    logic [GW-1:0] gap_cnt;
    logic          push_go;
    logic          gap_last;
    logic          fifo_ok;
    logic [7:0]    cur_byte;

`ifdef STATUS_FRAME_HEARTBEAT_EN
    logic [31:0] hb_cnt;

    assign hb_tick = (hb_cnt == 32'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt <= 32'd0;
        end else if (hb_tick) begin
            hb_cnt <= 32'd0;
        end else begin
            hb_cnt <= hb_cnt + 32'd1;
        end
    end
`else
    assign hb_tick = 1'b0;
`endif

    assign fifo_ok = (tf_counter < COUNTER_W'(FIFO_DEPTH));

    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            3'd0:    cur_byte = 8'hEB;
            3'd1:    cur_byte = 8'h90;
            3'd2:    cur_byte = seq_out;
            3'd3:    cur_byte = TAG;
            3'd4:    cur_byte = payload;
            3'd5:    cur_byte = chk;
            3'd6:    cur_byte = 8'h09;
            default: cur_byte = 8'hD7;
        endcase
    end

    // A push is only issued when the previous cycle had none, so the
    // FIFO occupancy seen here already includes the last byte written.
    always_comb begin
        state_next = state;
        push_go    = 1'b0;
        gap_last   = 1'b0;
        case (state)
            IDLE: begin
                if (pending) state_next = LOAD;
            end
            LOAD: state_next = SEND;
            SEND: begin
                if (!tf_push && fifo_ok) begin
                    push_go = 1'b1;
                    if (idx == 3'd7) state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_last   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= 1'b0;
            payload    <= 8'h00;
            chk        <= 8'h00;
            idx        <= 3'd0;
            gap_cnt    <= '0;
            tf_push    <= 1'b0;
            tdr        <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            seq_out    <= 8'h00;
        end else begin
            pending    <= (pending && state != LOAD) || send_req || hb_tick;
            tf_push    <= push_go;
            frame_done <= gap_last;
            if (state == IDLE && pending) busy <= 1'b1;
            if (gap_last) busy <= 1'b0;
            if (gap_last) seq_out <= seq_out + 8'd1;
            if (state == LOAD) begin
                payload <= status_in;
                chk     <= 8'h00 - (seq_out + TAG + status_in);
                idx     <= 3'd0;
            end
            if (push_go) begin
                tdr <= cur_byte;
                idx <= idx + 3'd1;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_status_frame_tx.sv
// Directed bench for status_frame_tx: frame bytes, stall, coalescing,
// sequence wrap, mid-frame reset and heartbeat/no-heartbeat.
module tb_status_frame_tx;

    localparam int GAP = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_req = 1'b0;
    logic [7:0] status_in = 8'h00;
    logic [4:0] tf_counter = 5'd0;
    logic       tf_push;
    logic [7:0] tdr;
    logic       busy;
    logic       frame_done;
    logic [7:0] seq_out;

    status_frame_tx #(
        .GAP_CYCLES(GAP),
        .PERIOD(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .send_req(send_req),
        .status_in(status_in),
        .tf_counter(tf_counter),
        .tf_push(tf_push),
        .tdr(tdr),
        .busy(busy),
        .frame_done(frame_done),
        .seq_out(seq_out)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         adj_err = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       prev_push = 1'b0;
    logic [7:0] bytes[$];
    int         stamps[$];

    // Outputs are sampled 1ns after the active edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (tf_push) begin
            bytes.push_back(tdr);
            stamps.push_back(cyc);
            if (prev_push) adj_err++;
        end
        prev_push = tf_push;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req_only();
        @(negedge clk);
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    task automatic pulse_req(logic [7:0] st);
        @(negedge clk);
        status_in = st;
        send_req  = 1'b1;
        @(negedge clk);
        send_req  = 1'b0;
    endtask

    task automatic wait_done(int target, int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_bytes(int target, int budget);
        int n = 0;
        while (bytes.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("bytes_timeout", 32'(bytes.size() >= target), 32'd1);
    endtask

    task automatic clear_q();
        bytes.delete();
        stamps.delete();
    endtask

    task automatic check_frame(int base, logic [7:0] seq, logic [7:0] pay);
        logic [7:0] exp[8];
        exp[0] = 8'hEB;
        exp[1] = 8'h90;
        exp[2] = seq;
        exp[3] = 8'hBA;
        exp[4] = pay;
        exp[5] = 8'h00 - (seq + 8'hBA + pay);
        exp[6] = 8'h09;
        exp[7] = 8'hD7;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("frame_b%0d", k),
                  32'(bytes[base + k]), 32'(exp[k]));
        end
    endtask

    initial begin
        int tgt;
        logic [7:0] pay;
        logic [7:0] sum;

        tick(3);
        check("rst_push", 32'(tf_push), 32'd0);
        check("rst_tdr", 32'(tdr), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_seq", 32'(seq_out), 32'h00);
        rst = 1'b0;
        tick(2);

        // single frame, payload changed right after LOAD
        clear_q();
        tgt = done_cnt + 1;
        pulse_req(8'h35);
        tick(1);
        check("busy_on_load", 32'(busy), 32'd1);
        tick(1);
        status_in = 8'hFF;
        wait_done(tgt, 500);
        check("single_len", 32'(bytes.size()), 32'd8);
        check("single_chk", 32'(bytes[5]), 32'h11);
        check_frame(0, 8'h00, 8'h35);
        check("single_span", 32'(stamps[7] - stamps[0]), 32'd14);
        check("single_gap", 32'(done_cyc - stamps[7]), 32'(GAP));
        check("single_seq", 32'(seq_out), 32'h01);
        check("single_busy", 32'(busy), 32'd0);

        // FIFO full after b2
        clear_q();
        tgt = done_cnt + 1;
        pulse_req(8'h5A);
        wait_bytes(3, 200);
        tf_counter = 5'd16;
        tick(50);
        check("stall_len", 32'(bytes.size()), 32'd3);
        check("stall_busy", 32'(busy), 32'd1);
        tf_counter = 5'd0;
        wait_done(tgt, 500);
        check("stall_resume", 32'(bytes[3]), 32'hBA);
        check("stall_total", 32'(bytes.size()), 32'd8);
        check_frame(0, 8'h01, 8'h5A);

        // request during LOAD re-arms for a second frame
        clear_q();
        tgt = done_cnt + 2;
        pulse_req(8'h11);
        req_only();
        tick(3);
        status_in = 8'h66;
        wait_done(tgt, 800);
        tick(50);
        check("rearm_len", 32'(bytes.size()), 32'd16);
        check_frame(0, 8'h02, 8'h11);
        check_frame(8, 8'h03, 8'h66);

        // three requests while busy coalesce into one frame
        clear_q();
        tgt = done_cnt + 2;
        pulse_req(8'h44);
        tick(5);
        req_only();
        tick(10);
        req_only();
        tick(10);
        req_only();
        status_in = 8'h55;
        wait_done(tgt, 800);
        tick(400);
        check("coal_len", 32'(bytes.size()), 32'd16);
        check_frame(0, 8'h04, 8'h44);
        check_frame(8, 8'h05, 8'h55);
        check("coal_space", 32'((stamps[8] - stamps[7]) >= GAP), 32'd1);

        // reset after three bytes
        clear_q();
        pulse_req(8'h77);
        wait_bytes(3, 200);
        rst = 1'b1;
        tick(1);
        check("mrst_push", 32'(tf_push), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_seq", 32'(seq_out), 32'h00);
        rst = 1'b0;
        tick(40);
        check("mrst_noresume", 32'(bytes.size()), 32'd3);

        // 257 frames: seq 00..FF then 00
        for (int i = 0; i < 257; i++) begin
            clear_q();
            pay = 8'(i * 7 + 3);
            tgt = done_cnt + 1;
            pulse_req(pay);
            wait_done(tgt, 1000);
            sum = bytes[2] + bytes[3] + bytes[4] + bytes[5];
            check("wrap_len", 32'(bytes.size()), 32'd8);
            check("wrap_b0", 32'(bytes[0]), 32'hEB);
            check("wrap_seq", 32'(bytes[2]), 32'(i % 256));
            check("wrap_pay", 32'(bytes[4]), 32'(pay));
            check("wrap_sum", 32'(sum), 32'h00);
            check("wrap_b7", 32'(bytes[7]), 32'hD7);
            if (i == 255) check("seq_ff_wrap", 32'(seq_out), 32'h00);
        end
        check("wrap_seq_end", 32'(seq_out), 32'h01);

`ifdef STATUS_FRAME_HEARTBEAT_EN
        clear_q();
        wait_bytes(9, 3000);
        check("hb_period", 32'(stamps[8] - stamps[0]), 32'd1000);
        check("hb_b0", 32'(bytes[8]), 32'hEB);
`else
        clear_q();
        tick(3000);
        check("no_hb", 32'(bytes.size()), 32'd0);
        check("no_hb_busy", 32'(busy), 32'd0);
`endif

        check("adjacent_push", 32'(adj_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
